// File: rtl/cache_master.sv
// rtl/cache_master.sv - CPU-facing cache controller with write-through memory path
// Looks up the cache, fills lines from memory on a read miss, and bounds every memory wait.
module cache_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ready,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_err,
  output logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data,
  output logic                  cs,
  output logic                  we,
  output logic                  re,
  output logic                  rpe,
  input  logic                  hit,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [CNT_WIDTH-1:0]  hit_cnt,
  output logic [CNT_WIDTH-1:0]  miss_cnt
);
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_RD, REFILL, WRITE, MEM_WR, RESP} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] fill_q, fill_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [CNT_WIDTH-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0]  miss_cnt_q, miss_cnt_d;
  logic                  drive;
  logic [DATA_WIDTH-1:0] dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      fill_q     <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      wait_q     <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      fill_q     <= fill_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      wait_q     <= wait_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    fill_d     = fill_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    wait_d     = wait_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    cpu_ready  = 1'b0;
    cpu_rvalid = 1'b0;
    cpu_err    = 1'b0;
    cs         = 1'b0;
    re         = 1'b0;
    we         = 1'b0;
    rpe        = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    drive      = 1'b0;
    dout       = wdata_q;
    case (state_q)
      IDLE: begin
        cpu_ready = rst_n;
        if (cpu_req) begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          err_d   = 1'b0;
          state_d = cpu_we ? WRITE : LOOKUP;
        end
      end
      LOOKUP: begin
        cs = 1'b1;
        re = 1'b1;
        if (hit) begin
          rdata_d   = data;
          hit_cnt_d = (&hit_cnt_q) ? hit_cnt_q : hit_cnt_q + 1'b1;
          state_d   = RESP;
        end else begin
          miss_cnt_d = (&miss_cnt_q) ? miss_cnt_q : miss_cnt_q + 1'b1;
          wait_d     = '0;
          state_d    = MEM_RD;
        end
      end
      MEM_RD: begin
        mem_req = 1'b1;
        // An ack on the final allowed cycle still wins over the timeout.
        if (mem_ack) begin
          rdata_d = mem_rdata;
          fill_d  = mem_rdata;
          state_d = REFILL;
        end else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      REFILL: begin
        cs      = 1'b1;
        rpe     = 1'b1;
        drive   = 1'b1;
        dout    = fill_q;
        state_d = RESP;
      end
      WRITE: begin
        cs      = 1'b1;
        we      = 1'b1;
        drive   = 1'b1;
        wait_d  = '0;
        state_d = MEM_WR;
      end
      MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) begin
          rdata_d = wdata_q;
          state_d = RESP;
        end else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      RESP: begin
        cpu_rvalid = 1'b1;
        cpu_err    = err_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign data      = drive ? dout : 'z;
  assign addr      = addr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rdata = rdata_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;
endmodule

// File: tb/tb_cache_master.sv
// tb/tb_cache_master.sv - randomized transaction-level bench for cache_master
// Plays both cache and memory; each transaction's cycle-by-cycle outcome is predicted up front.
module tb_cache_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam int CW = 3;
  localparam int CNT_MAX = (1 << CW) - 1;

  // expected {cs,re,we,rpe,mem_req,mem_we,cpu_rvalid,cpu_ready}
  localparam logic [7:0] S_IDLE   = 8'b0000_0001;
  localparam logic [7:0] S_LOOK   = 8'b1100_0000;
  localparam logic [7:0] S_WRITE  = 8'b1010_0000;
  localparam logic [7:0] S_REFILL = 8'b1001_0000;
  localparam logic [7:0] S_MRD    = 8'b0000_1000;
  localparam logic [7:0] S_MWR    = 8'b0000_1100;
  localparam logic [7:0] S_RESP   = 8'b0000_0010;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic cpu_ready, cpu_rvalid, cpu_err;
  logic [DW-1:0] cpu_rdata;
  logic [AW-1:0] addr, mem_addr;
  wire  [DW-1:0] data;
  logic cs, we, re, rpe;
  logic hit = 1'b0;
  logic mem_req, mem_we, mem_ack = 1'b0;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [CW-1:0] hit_cnt, miss_cnt;
  logic [DW-1:0] cache_data = '0;

  int vectors = 0;
  int miscompares = 0;
  int hit_m = 0;
  int miss_m = 0;

  assign data = re ? cache_data : 'z;

  always #5 clk = ~clk;

  cache_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .addr(addr), .data(data), .cs(cs), .we(we), .re(re), .rpe(rpe), .hit(hit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic strobes(input string tag, input logic [7:0] e);
    chk(tag, {56'd0, cs, re, we, rpe, mem_req, mem_we, cpu_rvalid, cpu_ready}, {56'd0, e});
  endtask

  task automatic noise();
    hit = 1'($urandom);
    mem_ack = 1'($urandom);
    mem_rdata = $urandom;
    cache_data = $urandom;
  endtask

  task automatic junk_cpu();
    cpu_req = 1'($urandom);
    cpu_we = 1'($urandom);
    cpu_addr = $urandom;
    cpu_wdata = $urandom;
  endtask

  task automatic idle_cycle();
    @(negedge clk); noise(); junk_cpu(); cpu_req = 1'b0; #1;
    strobes("idle", S_IDLE);
  endtask

  // lat = number of waiting cycles before ack; lat >= TO means memory never answers
  task automatic do_txn(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] wd, input bit h,
                        input logic [DW-1:0] cd, input int lat, input logic [DW-1:0] md);
    logic [DW-1:0] exp_rd;
    bit ok;
    int waits;
    @(negedge clk); noise(); cpu_req = 1'b1; cpu_we = w; cpu_addr = a; cpu_wdata = wd; #1;
    strobes("accept", S_IDLE);
    @(negedge clk); noise(); junk_cpu(); hit = h; cache_data = cd; #1;
    chk("addr_first", addr, a);
    if (w) begin
      strobes("write", S_WRITE);
      chk("write_bus", data, wd);
    end else begin
      strobes("lookup", S_LOOK);
    end
    if (!w && h) begin
      hit_m = (hit_m < CNT_MAX) ? hit_m + 1 : CNT_MAX;
      exp_rd = cd;
      ok = 1'b1;
    end else begin
      if (!w) miss_m = (miss_m < CNT_MAX) ? miss_m + 1 : CNT_MAX;
      ok = (lat < TO);
      waits = ok ? lat + 1 : TO;
      for (int i = 0; i < waits; i++) begin
        @(negedge clk); noise(); junk_cpu(); mem_ack = (i == lat);
        if (i == lat) mem_rdata = md;
        #1;
        strobes(w ? "mem_wr" : "mem_rd", w ? S_MWR : S_MRD);
        chk("mem_addr", mem_addr, a);
        if (w) chk("mem_wdata", mem_wdata, wd);
      end
      exp_rd = !ok ? '0 : (w ? wd : md);
      if (ok && !w) begin
        @(negedge clk); noise(); junk_cpu(); #1;
        strobes("refill", S_REFILL);
        chk("refill_bus", data, md);
        chk("addr_refill", addr, a);
      end
    end
    @(negedge clk); noise(); junk_cpu(); #1;
    strobes("resp", S_RESP);
    chk("rdata", cpu_rdata, exp_rd);
    chk("err", cpu_err, !ok);
    chk("addr_resp", addr, a);
    chk("hit_cnt", hit_cnt, hit_m);
    chk("miss_cnt", miss_cnt, miss_m);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_strobes", {cs, re, we, rpe, mem_req, mem_we, cpu_rvalid, cpu_err}, 8'h00);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_addr", {addr, mem_addr}, 0);
    chk("rst_cnt", {hit_cnt, miss_cnt}, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    strobes("post_rst", S_IDLE);

    do_txn(1'b0, 32'hAA, 32'h0, 1'b1, 32'h55, 0, 32'h0);
    do_txn(1'b0, 32'hFF, 32'h0, 1'b0, 32'h0, 2, 32'hA5);
    do_txn(1'b1, 32'h20, 32'hBB, 1'b0, 32'h0, 1, 32'h0);
    do_txn(1'b0, 32'h44, 32'h0, 1'b0, 32'h0, TO, 32'h0);
    do_txn(1'b0, 32'h48, 32'h0, 1'b0, 32'h0, TO - 1, 32'h5A5A);
    do_txn(1'b1, 32'h4C, 32'hCAFE, 1'b0, 32'h0, TO + 1, 32'h0);
    do_txn(1'b1, 32'h50, 32'hBEEF, 1'b0, 32'h0, TO - 1, 32'h0);
    idle_cycle();

    // abandon a read miss while it waits on memory
    @(negedge clk); noise(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1234; #1;
    @(negedge clk); noise(); junk_cpu(); hit = 1'b0; #1;
    repeat (2) begin
      @(negedge clk); noise(); junk_cpu(); mem_ack = 1'b0; #1;
      strobes("pre_abort", S_MRD);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("abort_strobes", {cs, re, we, rpe, mem_req, mem_we, cpu_rvalid, cpu_err}, 8'h00);
    chk("abort_cnt", {hit_cnt, miss_cnt}, 0);
    chk("abort_addr", {addr, mem_addr}, 0);
    chk("abort_rdata", cpu_rdata, 0);
    hit_m = 0;
    miss_m = 0;
    @(negedge clk); cpu_req = 1'b0; rst_n = 1'b1; #1;
    strobes("abort_release", S_IDLE);
    repeat (3) idle_cycle();

    // drive the hit counter into saturation
    repeat (CNT_MAX + 2) do_txn(1'b0, $urandom, $urandom, 1'b1, $urandom, 0, 32'h0);

    for (int n = 0; n < 120; n++) begin
      do_txn(1'($urandom), $urandom, $urandom, 1'($urandom), $urandom,
             int'($urandom_range(0, TO + 1)), $urandom);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
